// File: rtl/uart_cfg_pkg.sv
// Shared definitions for the run-time configurable UART: FSM state encoding,
// parity helper and the legacy 250 kbaud divisor.
package uart_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic [15:0] DIV_250K = 16'd3;

    // Callers zero-extend narrower frames, so unused high bits do not disturb the XOR.
    function automatic logic par(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/fifo.sv
// First-word-fall-through FIFO with 2**W entries of B bits; rd on empty and
// wr on full are ignored, but rd+wr on full performs both.
module fifo #(
    parameter int B = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    output logic         empty,
    output logic         full,
    output logic [B-1:0] r_data
);

    logic [B-1:0] mem_r [2**W];
    logic [W:0]   wptr_r;
    logic [W:0]   rptr_r;
    logic         wr_en_s;
    logic         rd_en_s;

    assign empty  = (wptr_r == rptr_r);
    assign full   = (wptr_r[W] != rptr_r[W]) && (wptr_r[W-1:0] == rptr_r[W-1:0]);
    assign r_data = mem_r[rptr_r[W-1:0]];

    // Write enable honours a same-cycle read so a full FIFO can stream.
    always_comb begin
        rd_en_s = rd & ~empty;
        wr_en_s = wr & (~full | rd);
    end

    // Storage array; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wptr_r[W-1:0]] <= w_data;
        end
    end

    // Pointer update with one wrap bit to tell full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (wr_en_s) begin
                wptr_r <= wptr_r + {{W{1'b0}}, 1'b1};
            end
            if (rd_en_s) begin
                rptr_r <= rptr_r + {{W{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/uart_cfg_rx.sv
// UART receiver: oversampled start detection with glitch rejection, LSB-first
// data, optional parity check and first-stop-bit framing check.
module uart_cfg_rx
    import uart_cfg_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            rx,
    input  logic            par_en,
    input  logic            par_odd,
    output logic            done,
    output logic [DBIT-1:0] dout,
    output logic            perr,
    output logic            ferr
);

    localparam int S_W = $clog2(SB_TICK);
    localparam int N_W = $clog2(DBIT);
    localparam logic [S_W-1:0] S_MID  = S_W'(SB_TICK / 2 - 1);
    localparam logic [S_W-1:0] S_END  = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

    uart_state_e    state_r;
    logic [S_W-1:0] s_r;
    logic [N_W-1:0] n_r;
    logic           par_en_r;
    logic           par_odd_r;

    // Receive FSM; the stop state ends at the first stop-bit midpoint so the
    // next start edge is caught even with two stop bits on the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            s_r       <= '0;
            n_r       <= '0;
            par_en_r  <= 1'b0;
            par_odd_r <= 1'b0;
            dout      <= '0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!rx) begin
                        state_r   <= ST_START;
                        s_r       <= '0;
                        par_en_r  <= par_en;
                        par_odd_r <= par_odd;
                        perr      <= 1'b0;
                        ferr      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (s_r == S_MID) begin
                            s_r <= '0;
                            n_r <= '0;
                            state_r <= rx ? ST_IDLE : ST_DATA;
                        end else begin
                            s_r <= s_r + S_W'(1'b1);
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (s_r == S_END) begin
                            s_r  <= '0;
                            dout <= {rx, dout[DBIT-1:1]};
                            if (n_r == N_LAST) begin
                                state_r <= par_en_r ? ST_PARITY : ST_STOP;
                            end else begin
                                n_r <= n_r + N_W'(1'b1);
                            end
                        end else begin
                            s_r <= s_r + S_W'(1'b1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        if (s_r == S_END) begin
                            s_r     <= '0;
                            perr    <= rx ^ par(8'(dout), par_odd_r);
                            state_r <= ST_STOP;
                        end else begin
                            s_r <= s_r + S_W'(1'b1);
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (s_r == S_END) begin
                            s_r     <= '0;
                            ferr    <= ~rx;
                            done    <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            s_r <= s_r + S_W'(1'b1);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_cfg.sv
// Full-duplex UART with run-time baud divisor, parity mode and stop-bit count,
// FIFO-buffered on both directions with per-byte RX error flags.
module uart_cfg
    import uart_cfg_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int FIFO_W  = 2,
    parameter int DIV_W   = 16,
    parameter int SB_TICK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    input  logic             par_en,
    input  logic             par_odd,
    input  logic             two_stop,
    input  logic             wr_uart,
    input  logic [7:0]       w_data,
    input  logic             rd_uart,
    input  logic             clr_err,
    input  logic             rx,
    output logic             tx,
    output logic             tx_full,
    output logic             rx_empty,
    output logic [7:0]       r_data,
    output logic             r_ferr,
    output logic             r_perr,
    output logic             overrun
);

    localparam int TS_W = $clog2(2 * SB_TICK);
    localparam int N_W  = $clog2(DBIT);
    localparam logic [TS_W-1:0] TS_END1 = TS_W'(SB_TICK - 1);
    localparam logic [TS_W-1:0] TS_END2 = TS_W'(2 * SB_TICK - 1);
    localparam logic [N_W-1:0]  N_LAST  = N_W'(DBIT - 1);

    logic [DIV_W-1:0] cnt_r;
    logic             tick_s;

    uart_state_e      tx_state_r;
    logic [TS_W-1:0]  tx_s_r;
    logic [N_W-1:0]   tx_n_r;
    logic [DBIT-1:0]  tx_b_r;
    logic             tx_pbit_r;
    logic             tx_par_en_r;
    logic             tx_two_stop_r;
    logic             tx_r;
    logic             tx_empty_s;
    logic             tx_stop_end_s;
    logic             tx_load_s;
    logic [DBIT-1:0]  tx_head_s;

    logic             rx_done_s;
    logic [DBIT-1:0]  rx_dout_s;
    logic             rx_perr_s;
    logic             rx_ferr_s;
    logic             rx_full_s;
    logic [DBIT+1:0]  rx_head_s;
    logic             overrun_r;

    assign tick_s  = (cnt_r == div);
    assign tx      = tx_r;
    assign overrun = overrun_r;
    assign r_ferr  = rx_head_s[DBIT];
    assign r_perr  = rx_head_s[DBIT+1];

    // Baud counter; the >= compare recovers at once when div shrinks below the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (cnt_r >= div) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + DIV_W'(1'b1);
        end
    end

    // A new byte is taken from idle or directly at the end of the stop period.
    always_comb begin
        tx_stop_end_s = 1'b0;
        if ((tx_state_r == ST_STOP) && tick_s) begin
            tx_stop_end_s = (tx_s_r == (tx_two_stop_r ? TS_END2 : TS_END1));
        end else begin
            tx_stop_end_s = 1'b0;
        end
        tx_load_s = ~tx_empty_s & ((tx_state_r == ST_IDLE) | tx_stop_end_s);
    end

    // Zero-extended FWFT view of the RX head.
    always_comb begin
        r_data = 8'd0;
        r_data[DBIT-1:0] = rx_head_s[DBIT-1:0];
    end

    fifo #(.B(DBIT), .W(FIFO_W)) u_tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .rd     (tx_load_s),
        .wr     (wr_uart),
        .w_data (w_data[DBIT-1:0]),
        .empty  (tx_empty_s),
        .full   (tx_full),
        .r_data (tx_head_s)
    );

    // Transmit FSM; configuration and parity bit are captured with the byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_r    <= ST_IDLE;
            tx_s_r        <= '0;
            tx_n_r        <= '0;
            tx_b_r        <= '0;
            tx_pbit_r     <= 1'b0;
            tx_par_en_r   <= 1'b0;
            tx_two_stop_r <= 1'b0;
            tx_r          <= 1'b1;
        end else if (tx_load_s) begin
            tx_state_r    <= ST_START;
            tx_s_r        <= '0;
            tx_b_r        <= tx_head_s;
            tx_pbit_r     <= par(8'(tx_head_s), par_odd);
            tx_par_en_r   <= par_en;
            tx_two_stop_r <= two_stop;
            tx_r          <= 1'b0;
        end else if (tick_s) begin
            case (tx_state_r)
                ST_IDLE: begin
                    tx_r <= 1'b1;
                end
                ST_START: begin
                    if (tx_s_r == TS_END1) begin
                        tx_s_r     <= '0;
                        tx_n_r     <= '0;
                        tx_state_r <= ST_DATA;
                        tx_r       <= tx_b_r[0];
                    end else begin
                        tx_s_r <= tx_s_r + TS_W'(1'b1);
                    end
                end
                ST_DATA: begin
                    if (tx_s_r == TS_END1) begin
                        tx_s_r <= '0;
                        tx_b_r <= {1'b0, tx_b_r[DBIT-1:1]};
                        if (tx_n_r == N_LAST) begin
                            tx_state_r <= tx_par_en_r ? ST_PARITY : ST_STOP;
                            tx_r       <= tx_par_en_r ? tx_pbit_r : 1'b1;
                        end else begin
                            tx_n_r <= tx_n_r + N_W'(1'b1);
                            tx_r   <= tx_b_r[1];
                        end
                    end else begin
                        tx_s_r <= tx_s_r + TS_W'(1'b1);
                    end
                end
                ST_PARITY: begin
                    if (tx_s_r == TS_END1) begin
                        tx_s_r     <= '0;
                        tx_state_r <= ST_STOP;
                        tx_r       <= 1'b1;
                    end else begin
                        tx_s_r <= tx_s_r + TS_W'(1'b1);
                    end
                end
                ST_STOP: begin
                    if (tx_stop_end_s) begin
                        tx_s_r     <= '0;
                        tx_state_r <= ST_IDLE;
                    end else begin
                        tx_s_r <= tx_s_r + TS_W'(1'b1);
                    end
                end
                default: begin
                    tx_state_r <= ST_IDLE;
                    tx_r       <= 1'b1;
                end
            endcase
        end
    end

    uart_cfg_rx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) u_rx (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick_s),
        .rx      (rx),
        .par_en  (par_en),
        .par_odd (par_odd),
        .done    (rx_done_s),
        .dout    (rx_dout_s),
        .perr    (rx_perr_s),
        .ferr    (rx_ferr_s)
    );

    fifo #(.B(DBIT + 2), .W(FIFO_W)) u_rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd_uart),
        .wr     (rx_done_s),
        .w_data ({rx_perr_s, rx_ferr_s, rx_dout_s}),
        .empty  (rx_empty),
        .full   (rx_full_s),
        .r_data (rx_head_s)
    );

    // Sticky overrun; a new drop wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (rx_done_s && rx_full_s && !rd_uart) begin
            overrun_r <= 1'b1;
        end else if (clr_err) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

endmodule

// File: tb/tb_uart_cfg.sv
// Directed self-checking bench for uart_cfg: TX framing/timing, loopback,
// RX error flags, overrun, glitch rejection, mid-frame reset and divisor change.
module tb_uart_cfg;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] div;
    logic        par_en, par_odd, two_stop;
    logic        wr_uart, rd_uart, clr_err;
    logic [7:0]  w_data;
    logic        rx_drv, loop_en, rx_s;
    logic        tx, tx_full, rx_empty, r_ferr, r_perr, overrun;
    logic [7:0]  r_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic mon_en = 1'b0;
    logic mon_full;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (!mon_en) mon_full <= 1'b0;
        else if (tx_full) mon_full <= 1'b1;
    end

    assign rx_s = loop_en ? tx : rx_drv;

    uart_cfg #(.DBIT(8), .FIFO_W(2), .DIV_W(16), .SB_TICK(16)) dut (
        .clk(clk), .reset(reset), .div(div), .par_en(par_en), .par_odd(par_odd),
        .two_stop(two_stop), .wr_uart(wr_uart), .w_data(w_data), .rd_uart(rd_uart),
        .clr_err(clr_err), .rx(rx_s), .tx(tx), .tx_full(tx_full), .rx_empty(rx_empty),
        .r_data(r_data), .r_ferr(r_ferr), .r_perr(r_perr), .overrun(overrun)
    );

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk); wr_uart = 1'b1; w_data = b;
        @(negedge clk); wr_uart = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk); rd_uart = 1'b1;
        @(negedge clk); rd_uart = 1'b0;
    endtask

    task automatic wait_low(output int t);
        int k = 0;
        t = -1;
        while (t < 0 && k < 4000) begin
            @(negedge clk);
            if (tx === 1'b0) t = cyc;
            k++;
        end
        n_cmp++;
        if (t < 0) begin n_err++; $display("FAIL tx_start_timeout: no start bit seen, expected one within 4000 cycles"); end
    endtask

    task automatic wait_edge(output int t);
        int k = 0;
        logic prev;
        prev = tx;
        t = -1;
        while (t < 0 && k < 2000) begin
            @(negedge clk);
            if (tx !== prev) t = cyc;
            k++;
        end
        n_cmp++;
        if (t < 0) begin n_err++; $display("FAIL tx_edge_timeout: no tx transition, expected one within 2000 cycles"); end
    endtask

    // Drives one frame on rx at 64 clk per bit (div=3); a bad stop bit is held low only 40 clk.
    task automatic send_rx(input logic [7:0] d, input logic pen, input logic pbit, input logic stop_bit);
        @(negedge clk); rx_drv = 1'b0;
        repeat (63) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (64) @(negedge clk);
        end
        if (pen) begin
            rx_drv = pbit;
            repeat (64) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (stop_bit ? 64 : 40) @(negedge clk);
        rx_drv = 1'b1;
        repeat (64) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; div = 16'd3; par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0;
        wr_uart = 1'b0; rd_uart = 1'b0; clr_err = 1'b0; w_data = 8'h00;
        rx_drv = 1'b1; loop_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_cmp++; if (tx_full !== 1'b0) begin n_err++; $display("FAIL reset_tx_full: got %b expected 0", tx_full); end
        n_cmp++; if (rx_empty !== 1'b1) begin n_err++; $display("FAIL reset_rx_empty: got %b expected 1", rx_empty); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_tx_8n1();
        int f1, f2, f3;
        logic [9:0] frame;
        logic bad;
        frame = {1'b1, 8'hA5, 1'b0};
        par_en = 1'b0; two_stop = 1'b0; mon_en = 1'b1;
        push(8'hA5);
        wait_low(f1);
        push(8'hA5); push(8'hA5);
        wait_until(f1 + 600);
        wait_low(f2);
        for (int k = 0; k < 10; k++) begin
            bad = 1'b0;
            wait_until(f2 + 64 * k + 2);  if (tx !== frame[k]) bad = 1'b1;
            wait_until(f2 + 64 * k + 32); if (tx !== frame[k]) bad = 1'b1;
            wait_until(f2 + 64 * k + 62); if (tx !== frame[k]) bad = 1'b1;
            n_cmp++;
            if (bad) begin n_err++; $display("FAIL tx_8n1_bit%0d: got %b expected %b over the 64-clk bit", k, tx, frame[k]); end
        end
        wait_until(f2 + 620);
        wait_low(f3);
        n_cmp++; if (f3 - f2 != 640) begin n_err++; $display("FAIL tx_8n1_frame_len: got %0d expected 640", f3 - f2); end
        wait_until(f3 + 700);
        n_cmp++; if (mon_full !== 1'b0) begin n_err++; $display("FAIL tx_8n1_no_full: got %b expected 0", mon_full); end
        mon_en = 1'b0;
    endtask

    task automatic test_loopback();
        int f1, f2, f3;
        loop_en = 1'b1; par_en = 1'b1; par_odd = 1'b0; two_stop = 1'b1;
        push(8'h37);
        wait_low(f1);
        push(8'h37); push(8'h37);
        wait_until(f1 + 700);
        wait_low(f2);
        wait_until(f2 + 700);
        wait_low(f3);
        n_cmp++; if (f3 - f2 != 768) begin n_err++; $display("FAIL loop_frame_len: got %0d expected 768", f3 - f2); end
        n_cmp++; if (rx_empty !== 1'b0) begin n_err++; $display("FAIL loop_rx_empty: got %b expected 0", rx_empty); end
        n_cmp++; if (r_data !== 8'h37) begin n_err++; $display("FAIL loop_r_data: got %h expected 37", r_data); end
        n_cmp++; if ({r_perr, r_ferr} !== 2'b00) begin n_err++; $display("FAIL loop_err_flags: got %b expected 00", {r_perr, r_ferr}); end
        wait_until(f3 + 900);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({rx_empty, r_perr, r_ferr, r_data} !== {3'b000, 8'h37}) begin
                n_err++; $display("FAIL loop_entry%0d: got empty/perr/ferr/data %b%b%b/%h expected 000/37", i, rx_empty, r_perr, r_ferr, r_data);
            end
            pop();
        end
        n_cmp++; if (rx_empty !== 1'b1) begin n_err++; $display("FAIL loop_drained: got %b expected 1", rx_empty); end
        loop_en = 1'b0; two_stop = 1'b0;
    endtask

    task automatic test_rx_errors();
        par_en = 1'b1; par_odd = 1'b0;
        send_rx(8'h5A, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (rx_empty !== 1'b0) begin n_err++; $display("FAIL perr_rx_empty: got %b expected 0", rx_empty); end
        n_cmp++; if (r_data !== 8'h5A) begin n_err++; $display("FAIL perr_r_data: got %h expected 5a", r_data); end
        n_cmp++; if ({r_perr, r_ferr} !== 2'b10) begin n_err++; $display("FAIL perr_flags: got %b expected 10", {r_perr, r_ferr}); end
        pop();
        par_en = 1'b0;
        send_rx(8'hC3, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (r_data !== 8'hC3) begin n_err++; $display("FAIL ferr_r_data: got %h expected c3", r_data); end
        n_cmp++; if ({r_perr, r_ferr} !== 2'b01) begin n_err++; $display("FAIL ferr_flags: got %b expected 01", {r_perr, r_ferr}); end
        pop();
        n_cmp++; if (rx_empty !== 1'b1) begin n_err++; $display("FAIL ferr_drained: got %b expected 1", rx_empty); end
    endtask

    task automatic test_overrun();
        logic [7:0] d [5];
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        par_en = 1'b0;
        for (int i = 0; i < 4; i++) send_rx(d[i], 1'b0, 1'b0, 1'b1);
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_before: got %b expected 0", overrun); end
        send_rx(d[4], 1'b0, 1'b0, 1'b1);
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        @(negedge clk); clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({rx_empty, r_data} !== {1'b0, d[i]}) begin
                n_err++; $display("FAIL ovr_entry%0d: got empty/data %b/%h expected 0/%h", i, rx_empty, r_data, d[i]);
            end
            pop();
        end
        n_cmp++; if (rx_empty !== 1'b1) begin n_err++; $display("FAIL ovr_drained: got %b expected 1", rx_empty); end
    endtask

    task automatic test_glitch();
        @(negedge clk); rx_drv = 1'b0;
        repeat (12) @(negedge clk);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        n_cmp++; if (rx_empty !== 1'b1) begin n_err++; $display("FAIL glitch_rejected: got %b expected 1", rx_empty); end
        send_rx(8'h00, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (rx_empty !== 1'b0) begin n_err++; $display("FAIL glitch_then_rx_empty: got %b expected 0", rx_empty); end
        n_cmp++; if ({r_perr, r_ferr, r_data} !== 10'h000) begin n_err++; $display("FAIL glitch_then_byte: got %b%b/%h expected 00/00", r_perr, r_ferr, r_data); end
        pop();
    endtask

    task automatic test_reset_mid_frame();
        int f1;
        logic stayed;
        send_rx(8'h3C, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (rx_empty !== 1'b0) begin n_err++; $display("FAIL rst_pre_rx_empty: got %b expected 0", rx_empty); end
        push(8'hF0);
        wait_low(f1);
        for (int i = 0; i < 4; i++) push(8'h0F);
        n_cmp++; if (tx_full !== 1'b1) begin n_err++; $display("FAIL rst_pre_tx_full: got %b expected 1", tx_full); end
        wait_until(f1 + 266);
        n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL rst_pre_bit3: got %b expected 0", tx); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if ({tx, tx_full, rx_empty, overrun} !== 4'b1010) begin
            n_err++; $display("FAIL rst_mid_frame: got tx/full/empty/ovr %b%b%b%b expected 1010", tx, tx_full, rx_empty, overrun);
        end
        reset = 1'b0;
        stayed = 1'b1;
        repeat (100) begin @(negedge clk); if (tx !== 1'b1) stayed = 1'b0; end
        n_cmp++; if (stayed !== 1'b1) begin n_err++; $display("FAIL rst_tx_stays_idle: got %b expected 1", stayed); end
    endtask

    task automatic test_div_change();
        int f1, e0, e1, e2;
        div = 16'd3;
        push(8'h55);
        wait_low(f1);
        wait_until(f1 + 168);
        div = 16'd0;
        wait_edge(e0);
        wait_edge(e1);
        wait_edge(e2);
        n_cmp++; if (e1 - e0 != 16) begin n_err++; $display("FAIL div0_bit_a: got %0d expected 16", e1 - e0); end
        n_cmp++; if (e2 - e1 != 16) begin n_err++; $display("FAIL div0_bit_b: got %0d expected 16", e2 - e1); end
        repeat (300) @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL div0_idle: got %b expected 1", tx); end
        div = 16'd3;
    endtask

    initial begin
        test_reset();
        test_tx_8n1();
        test_loopback();
        test_rx_errors();
        test_overrun();
        test_glitch();
        test_reset_mid_frame();
        test_div_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_cfg.md
Name: uart_cfg

Overview:
Full-duplex UART with a baud divisor, parity mode and stop-bit count that are configurable at run time. It has per-byte error reporting (framing, parity) and a sticky RX overrun flag. It is the successor of the fixed 250000-baud 8N1 UART and keeps the same FIFO-buffered rd/wr host handshake. It sits between the CPU bus peripheral decoder and the board serial pins.

Parameters:
DBIT, 8, data bits per frame (legal 5..8)
FIFO_W, 2, log2 of RX and TX FIFO depth
DIV_W, 16, width of baud divisor input
SB_TICK, 16, oversampling ticks per bit

Ports:
clk  input  1  system clock (16 MHz)
reset  input  1  synchronous, active-high reset
div  input  DIV_W  baud tick period minus 1; tick rate = clk/(div+1); div=3 gives 250000 baud
par_en  input  1  parity bit enabled
par_odd  input  1  odd parity when 1, even when 0
two_stop  input  1  two stop bits when 1
wr_uart  input  1  push w_data into TX FIFO
w_data  input  8  TX byte; bits above DBIT-1 ignored
rd_uart  input  1  pop RX FIFO head
clr_err  input  1  clear sticky overrun flag
rx  input  1  serial in, idle high, already synchronised externally
tx  output  1  serial out, idle high
tx_full  output  1  TX FIFO full
rx_empty  output  1  RX FIFO empty
r_data  output  8  RX FIFO head data, zero-extended above DBIT
r_ferr  output  1  framing error of head byte
r_perr  output  1  parity error of head byte
overrun  output  1  sticky: a received frame was dropped because the RX FIFO was full

Behaviour:
- Reset values: tx=1, tx_full=0, rx_empty=1, overrun=0. Both FIFOs are emptied, the baud counter is cleared and both FSMs go to idle. A reset asserted mid-frame aborts the frame; tx is 1 on the next cycle.
- Baud gen: the counter runs 0..div and emits a 1-cycle tick when it reaches div, then wraps to 0. If div changes while the count is above the new div, the counter wraps to 0 on the next cycle. div=0 gives a tick every cycle.
- Config latch: par_en, par_odd and two_stop are sampled into each FSM when it leaves idle. Changes have no effect on a frame already in flight.
- TX FSM states: idle, start, data, parity, stop.
  - idle -> start when the TX FIFO is not empty. The head byte is loaded and the FIFO popped in the same cycle.
  - Each bit lasts SB_TICK ticks. Data is sent LSB first, DBIT bits.
  - parity state only when par_en. The parity bit is XOR of the data bits, inverted when par_odd.
  - stop state lasts SB_TICK or 2*SB_TICK ticks.
  - After stop: back-to-back start if the FIFO is not empty, else idle.
- RX FSM states: idle, start, data, parity, stop.
  - idle -> start on rx=0.
  - start: at tick count 7, if rx=1 go back to idle (glitch rejected); otherwise restart the count.
  - data: each bit is sampled at tick 15 of its bit period, shifted in LSB first.
  - parity: the sampled bit is compared with the computed parity; a mismatch sets perr.
  - stop: only the first stop bit is checked, sampled at its midpoint; rx=0 sets ferr. The receiver returns to idle after one bit period even when two_stop=1, so that resync is tolerant.
- Frame done: {perr, ferr, data} is written to the RX FIFO (width DBIT+2).
  - If the RX FIFO is full, the frame is dropped and overrun is set.
  - overrun stays set until clr_err; if clr_err and a new overrun happen in the same cycle, set wins.
- FIFO semantics: rd on empty and wr on full are ignored. Simultaneous rd and wr on a full FIFO performs both. r_data, r_ferr and r_perr show the head combinationally, first-word-fall-through.
- Frame length in clk cycles = (div+1)*SB_TICK*(1+DBIT+par_en+1+two_stop).

Decomposition:
- Package uart_cfg_pkg holds:
  - FSM state encodings (shared by rx and tx);
  - the parity function par(data, odd);
  - the constant DIV_250K=3.
- Reuse the existing fifo module for both FIFOs; the RX instance has B=DBIT+2.
- One natural new sub-module: uart_cfg_rx, the receiver FSM with parity and framing checks. The transmitter and baud counter stay inline.

Test Plan:
- div=3, 8N1, write 0xA5 -> tx shows start, 1,0,1,0,0,1,0,1, stop; each bit is 64 clk; the frame is 640 clk; tx_full never asserts.
- Loopback tx->rx, div=3, par_en=1, par_odd=0, two_stop=1, send 0x37 -> rx_empty falls; r_data=0x37, r_ferr=0, r_perr=0; tx frame is 768 clk.
- Drive rx with 0x5A and a wrong even-parity bit -> r_perr=1, r_ferr=0, r_data=0x5A. Drive a frame with stop=0 -> r_ferr=1.
- FIFO_W=2: receive 5 frames without rd_uart -> 4 entries held in order, overrun=1 after the 5th stop bit. clr_err -> overrun=0. rd x4 -> rx_empty=1.
- rx low pulse of 3 tick periods while idle -> no byte written, rx_empty stays 1. Then a valid 0x00 frame is received correctly.
- Assert reset mid TX data bit 3 -> tx=1 next cycle, tx_full=0, rx_empty=1. Change div 3->0 during a frame -> the new rate applies from the counter wrap with no lost tick state.
